// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin arbiter that gives NREQ requesters timed,
// exclusive access to a shared bank of NBITS JK flip-flops and reports completion.
module jk_bank_scheduler #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int IDXW  = 3,
   parameter int CNT_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*IDXW-1:0]      req_idx,
   input  logic [NREQ*2-1:0]         req_cmd,
   input  logic [NREQ*CNT_W-1:0]     req_cnt,
   output logic [NBITS-1:0]          j_out,
   output logic [NBITS-1:0]          k_out,
   input  logic [NBITS-1:0]          q_in,
   output logic                      done_valid,
   output logic [$clog2(NREQ)-1:0]   done_id,
   output logic                      done_q,
   output logic                      done_err
);

   localparam int IDW = $clog2(NREQ);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   logic [1:0]       state_r;
   logic             run_r;
   logic [IDW-1:0]   rr_r;
   logic [IDW-1:0]   id_r;
   logic [IDXW-1:0]  idx_r;
   logic [1:0]       cmd_r;
   logic [CNT_W-1:0] cnt_r;
   logic             err_r;
   logic [NBITS-1:0] j_r;
   logic [NBITS-1:0] k_r;
   logic             done_valid_r;
   logic [IDW-1:0]   done_id_r;
   logic             done_err_r;

   int               cand_s;
   logic             hit_s;
   logic             grant_any_s;
   logic [IDW-1:0]   grant_id_s;
   logic [NREQ-1:0]  ready_s;
   logic [IDXW-1:0]  sel_idx_s;
   logic [1:0]       sel_cmd_s;
   logic [CNT_W-1:0] sel_cnt_s;
   logic             sel_err_s;
   logic [NBITS-1:0] sel_j_s;
   logic [NBITS-1:0] sel_k_s;
   logic             done_q_s;

   // Round-robin scan starting at rr_r; first valid requester wins.
   always_comb begin
      cand_s      = 0;
      hit_s       = 1'b0;
      grant_any_s = 1'b0;
      grant_id_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand_s      = (int'(rr_r) + i) % NREQ;
         hit_s       = req_valid[cand_s] & ~grant_any_s;
         grant_id_s  = hit_s ? IDW'(cand_s) : grant_id_s;
         grant_any_s = grant_any_s | hit_s;
      end
   end

   // Grant is only offered from IDLE once the first post-reset edge has passed.
   always_comb begin
      ready_s = '0;
      if ((state_r == ST_IDLE) && run_r && grant_any_s) begin
         ready_s = NREQ'(1'b1) << grant_id_s;
      end else begin
         ready_s = '0;
      end
   end

   // Fields of the winning requester and the one-hot drive pattern they imply.
   always_comb begin
      sel_idx_s = req_idx[int'(grant_id_s)*IDXW +: IDXW];
      sel_cmd_s = req_cmd[int'(grant_id_s)*2 +: 2];
      sel_cnt_s = req_cnt[int'(grant_id_s)*CNT_W +: CNT_W];
      sel_cnt_s = (sel_cnt_s == '0) ? CNT_W'(1'b1) : sel_cnt_s;
      sel_err_s = (int'(sel_idx_s) >= NBITS);
      sel_j_s   = '0;
      sel_k_s   = '0;
      for (int b = 0; b < NBITS; b++) begin
         sel_j_s[b] = sel_cmd_s[1] & (sel_idx_s == IDXW'(b));
         sel_k_s[b] = sel_cmd_s[0] & (sel_idx_s == IDXW'(b));
      end
   end

   // Read back the target bit in CHECK; the bank has already taken the last edge.
   always_comb begin
      done_q_s = 1'b0;
      for (int b = 0; b < NBITS; b++) begin
         done_q_s = done_q_s | (q_in[b] & (idx_r == IDXW'(b)));
      end
      done_q_s = done_q_s & (state_r == ST_CHECK) & ~err_r;
   end

   // Scheduler FSM, latched command fields and registered bank drive/completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         run_r        <= 1'b0;
         rr_r         <= '0;
         id_r         <= '0;
         idx_r        <= '0;
         cmd_r        <= 2'b00;
         cnt_r        <= '0;
         err_r        <= 1'b0;
         j_r          <= '0;
         k_r          <= '0;
         done_valid_r <= 1'b0;
         done_id_r    <= '0;
         done_err_r   <= 1'b0;
      end else begin
         run_r        <= 1'b1;
         done_valid_r <= 1'b0;
         done_id_r    <= '0;
         done_err_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (|ready_s) begin
                  idx_r <= sel_idx_s;
                  cmd_r <= sel_cmd_s;
                  cnt_r <= sel_cnt_s;
                  id_r  <= grant_id_s;
                  err_r <= sel_err_s;
                  rr_r  <= (grant_id_s == IDW'(NREQ-1)) ? '0 : grant_id_s + IDW'(1);
                  if (sel_err_s) begin
                     state_r      <= ST_CHECK;
                     done_valid_r <= 1'b1;
                     done_id_r    <= grant_id_s;
                     done_err_r   <= 1'b1;
                  end else begin
                     state_r <= ST_ISSUE;
                     j_r     <= sel_j_s;
                     k_r     <= sel_k_s;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (cnt_r <= CNT_W'(1'b1)) begin
                  state_r      <= ST_CHECK;
                  cnt_r        <= '0;
                  j_r          <= '0;
                  k_r          <= '0;
                  done_valid_r <= 1'b1;
                  done_id_r    <= id_r;
                  done_err_r   <= err_r;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1'b1);
               end
            end
            ST_CHECK: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               j_r     <= '0;
               k_r     <= '0;
            end
         endcase
      end
   end

   assign req_ready  = ready_s;
   assign j_out      = j_r;
   assign k_out      = k_r;
   assign done_valid = done_valid_r;
   assign done_id    = done_id_r;
   assign done_err   = done_err_r;
   assign done_q     = done_q_s;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Self-checking bench for jk_bank_scheduler: directed scenarios plus a randomized
// run compared against a cycle-level model derived from the scheduling rules.
module tb_jk_bank_scheduler;
   localparam int NREQ  = 4;
   localparam int NBITS = 8;
   localparam int IDXW  = 4;
   localparam int CNT_W = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*IDXW-1:0]  req_idx;
   logic [NREQ*2-1:0]     req_cmd;
   logic [NREQ*CNT_W-1:0] req_cnt;
   logic [NBITS-1:0]      j_out;
   logic [NBITS-1:0]      k_out;
   logic [NBITS-1:0]      q_in;
   logic                  done_valid;
   logic [IDW-1:0]        done_id;
   logic                  done_q;
   logic                  done_err;

   logic [NBITS-1:0]      bank = 8'h00;
   logic [NBITS-1:0]      bits_m = 8'h00;
   int                    checks = 0;
   int                    errors = 0;

   jk_bank_scheduler #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_idx(req_idx), .req_cmd(req_cmd), .req_cnt(req_cnt),
      .j_out(j_out), .k_out(k_out), .q_in(q_in),
      .done_valid(done_valid), .done_id(done_id), .done_q(done_q), .done_err(done_err)
   );

   always #5 clk = ~clk;

   // The JK flip-flop bank itself; it is not touched by rst_n.
   always @(posedge clk) begin
      for (int b = 0; b < NBITS; b++) begin
         case ({j_out[b], k_out[b]})
            2'b01:   bank[b] <= 1'b0;
            2'b10:   bank[b] <= 1'b1;
            2'b11:   bank[b] <= ~bank[b];
            default: bank[b] <= bank[b];
         endcase
      end
   end
   assign q_in = bank;

   function automatic logic model_jk(input logic v, input logic [1:0] cmd, input int n);
      case (cmd)
         2'b00:   return v;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return v ^ n[0];
      endcase
   endfunction

   task automatic set_req(input int r, input int idx, input logic [1:0] cmd, input int cnt);
      req_idx[r*IDXW +: IDXW]   = IDXW'(idx);
      req_cmd[r*2 +: 2]         = cmd;
      req_cnt[r*CNT_W +: CNT_W] = CNT_W'(cnt);
      req_valid[r]              = 1'b1;
   endtask

   // One isolated command from an idle scheduler, checked cycle by cycle.
   task automatic do_cmd(input int r, input int idx, input logic [1:0] cmd, input int cnt);
      int n;
      logic err;
      logic eq;
      logic [NBITS-1:0] ej;
      logic [NBITS-1:0] ek;
      logic [NREQ-1:0] er;
      n  = (cnt == 0) ? 1 : cnt;
      err = (idx >= NBITS);
      ej = '0;
      ek = '0;
      er = '0;
      er[r] = 1'b1;
      if (!err) begin
         ej[idx] = cmd[1];
         ek[idx] = cmd[0];
         bits_m[idx] = model_jk(bits_m[idx], cmd, n);
      end
      eq = err ? 1'b0 : bits_m[idx];
      @(negedge clk);
      set_req(r, idx, cmd, cnt);
      #1;
      checks++;
      if (req_ready !== er) begin
         errors++;
         $display("FAIL cmd_ready r%0d idx%0d: got %b expected %b", r, idx, req_ready, er);
      end
      @(negedge clk);
      req_valid[r] = 1'b0;
      for (int c = 0; c < (err ? 0 : n); c++) begin
         #1;
         checks++;
         if ({j_out, k_out, done_valid, req_ready} !== {ej, ek, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL cmd_issue r%0d c%0d: got j=%h k=%h dv=%b rdy=%b expected j=%h k=%h dv=0 rdy=0",
                     r, c, j_out, k_out, done_valid, req_ready, ej, ek);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({done_valid, done_id, done_err, done_q, j_out, k_out} !== {1'b1, IDW'(r), err, eq, 16'h0000}) begin
         errors++;
         $display("FAIL cmd_done r%0d idx%0d: got dv=%b id=%0d err=%b q=%b j=%h k=%h expected 1 %0d %b %b 00 00",
                  r, idx, done_valid, done_id, done_err, done_q, j_out, k_out, r, err, eq);
      end
   endtask

   task automatic test_reset;
      for (int r = 0; r < NREQ; r++) set_req(r, r, 2'b10, 1);
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if ({req_ready, j_out, k_out, done_valid, done_id, done_q, done_err} !== 25'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b j=%h k=%h dv=%b id=%0d q=%b err=%b expected all 0",
                     req_ready, j_out, k_out, done_valid, done_id, done_q, done_err);
         end
      end
   endtask

   task automatic test_rr_all;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int pend[$];
      int got = 0;
      int dones = 0;
      int g;
      int e;
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 80 && dones < 5; cyc++) begin
         @(negedge clk);
         if (got == 5) req_valid = '0;
         #1;
         checks++;
         if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL rr_onehot: got %b expected at most one bit", req_ready);
         end
         if (req_ready != '0 && got < 5) begin
            g = 0;
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) g = r;
            checks++;
            if (g != exp_order[got]) begin
               errors++;
               $display("FAIL rr_order grant%0d: got %0d expected %0d", got, g, exp_order[got]);
            end
            pend.push_back(g);
            got++;
         end
         if (done_valid === 1'b1) begin
            dones++;
            checks++;
            if (pend.size() == 0) begin
               errors++;
               $display("FAIL rr_done: got unexpected done id %0d expected none", done_id);
            end else begin
               e = pend.pop_front();
               if ({done_id, done_q, done_err} !== {IDW'(e), 1'b1, 1'b0}) begin
                  errors++;
                  $display("FAIL rr_done: got id=%0d q=%b err=%b expected id=%0d q=1 err=0",
                           done_id, done_q, done_err, e);
               end
            end
         end
      end
      checks++;
      if (dones != 5) begin
         errors++;
         $display("FAIL rr_timeout: got %0d completions expected 5", dones);
      end
      bits_m[3:0] = 4'hF;
   endtask

   task automatic test_single;
      do_cmd(1, 5, 2'b10, 0);
   endtask

   task automatic test_toggle;
      do_cmd(0, 2, 2'b01, 1);
      do_cmd(0, 2, 2'b11, 3);
      do_cmd(0, 2, 2'b01, 1);
      do_cmd(0, 2, 2'b11, 4);
   endtask

   task automatic test_err;
      do_cmd(2, 9, 2'b11, 3);
      @(negedge clk);
      set_req(0, 0, 2'b00, 1);
      set_req(3, 3, 2'b00, 1);
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL err_rr_ptr: got %b expected 1000", req_ready);
      end
      @(negedge clk);
      req_valid[3] = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({done_valid, done_id, done_q} !== {1'b1, 2'd3, bits_m[3]}) begin
         errors++;
         $display("FAIL err_next_done: got dv=%b id=%0d q=%b expected 1 3 %b", done_valid, done_id, done_q, bits_m[3]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL err_then_r0: got %b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int k;
      @(negedge clk);
      set_req(1, 6, 2'b11, 5);
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL mid_accept: got %b expected 0010", req_ready);
      end
      @(negedge clk);
      req_valid[1] = 1'b0;
      set_req(3, 3, 2'b00, 1);
      set_req(0, 0, 2'b00, 1);
      @(negedge clk);
      #1;
      checks++;
      if ({j_out, k_out} !== 16'h4040) begin
         errors++;
         $display("FAIL mid_issue2: got j=%h k=%h expected j=40 k=40", j_out, k_out);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({j_out, k_out, done_valid, req_ready} !== 21'h0) begin
         errors++;
         $display("FAIL mid_async_clear: got j=%h k=%h dv=%b rdy=%b expected 0", j_out, k_out, done_valid, req_ready);
      end
      bits_m[6] = ~bits_m[6];
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (done_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: got %b expected 0", done_valid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      k = 0;
      while (k < 5 && req_ready == '0) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL mid_restart_r0: got %b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL mid_then_r3: got %b expected 1000", req_ready);
      end
      @(negedge clk);
      req_valid[3] = 1'b0;
      @(negedge clk);
      do_cmd(2, 6, 2'b00, 1);
   endtask

   task automatic test_hold;
      do_cmd(0, 4, 2'b10, 1);
      do_cmd(1, 4, 2'b00, 2);
   endtask

   task automatic test_random;
      int rr_m = 0;
      int free_cyc = 0;
      int done_cyc = -1;
      int iss_lo = 0;
      int iss_hi = -1;
      int drop = -1;
      int g;
      int n;
      int idx;
      int e_id = 0;
      logic e_q = 1'b0;
      logic e_err = 1'b0;
      logic [1:0] cmd;
      logic [NBITS-1:0] ej = '0;
      logic [NBITS-1:0] ek = '0;
      logic [NREQ-1:0] exp_rdy;
      logic [2*NBITS-1:0] exp_jk;
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if (drop >= 0) begin
            req_valid[drop] = 1'b0;
            drop = -1;
         end
         for (int r = 0; r < NREQ; r++) begin
            if (cyc >= 1480) req_valid[r] = 1'b0;
            else if (!req_valid[r] && $urandom_range(0, 3) == 0)
               set_req(r, int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            else if (req_valid[r] && $urandom_range(0, 19) == 0) req_valid[r] = 1'b0;
         end
         #1;
         exp_rdy = '0;
         g = -1;
         if (cyc >= free_cyc)
            for (int i = 0; i < NREQ; i++)
               if (g < 0 && req_valid[(rr_m + i) % NREQ]) g = (rr_m + i) % NREQ;
         if (g >= 0) exp_rdy[g] = 1'b1;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rnd_ready cyc%0d: got %b expected %b", cyc, req_ready, exp_rdy);
         end
         exp_jk = (cyc >= iss_lo && cyc <= iss_hi) ? {ej, ek} : 16'h0000;
         checks++;
         if ({j_out, k_out} !== exp_jk) begin
            errors++;
            $display("FAIL rnd_jk cyc%0d: got %h expected %h", cyc, {j_out, k_out}, exp_jk);
         end
         checks++;
         if (done_valid !== (cyc == done_cyc)) begin
            errors++;
            $display("FAIL rnd_done_valid cyc%0d: got %b expected %b", cyc, done_valid, cyc == done_cyc);
         end
         if (cyc == done_cyc) begin
            checks++;
            if ({done_id, done_q, done_err} !== {IDW'(e_id), e_q, e_err}) begin
               errors++;
               $display("FAIL rnd_done cyc%0d: got id=%0d q=%b err=%b expected id=%0d q=%b err=%b",
                        cyc, done_id, done_q, done_err, e_id, e_q, e_err);
            end
         end
         if (g >= 0) begin
            idx   = int'(req_idx[g*IDXW +: IDXW]);
            cmd   = req_cmd[g*2 +: 2];
            n     = int'(req_cnt[g*CNT_W +: CNT_W]);
            n     = (n == 0) ? 1 : n;
            e_err = (idx >= NBITS);
            e_id  = g;
            ej    = '0;
            ek    = '0;
            if (!e_err) begin
               ej[idx]     = cmd[1];
               ek[idx]     = cmd[0];
               bits_m[idx] = model_jk(bits_m[idx], cmd, n);
               e_q         = bits_m[idx];
               iss_lo      = cyc + 1;
               iss_hi      = cyc + n;
               done_cyc    = cyc + n + 1;
            end else begin
               e_q      = 1'b0;
               iss_lo   = 0;
               iss_hi   = -1;
               done_cyc = cyc + 1;
            end
            free_cyc = done_cyc + 1;
            rr_m     = (g + 1) % NREQ;
            drop     = g;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_idx   = '0;
      req_cmd   = '0;
      req_cnt   = '0;
      test_reset;
      test_rr_all;
      test_single;
      test_toggle;
      test_err;
      test_reset_mid;
      test_hold;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
